// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says colour pad blocks.
package simon_pkg;

    typedef enum logic [1:0] {IDLE, ON, GAP, FINISH} seq_state_t;

    localparam int DEF_NUM_COLOURS = 4;
    localparam int DEF_MAX_STEPS   = 32;

    localparam int RED    = 0;
    localparam int GREEN  = 1;
    localparam int BLUE   = 2;
    localparam int YELLOW = 3;

    // Width of a counter that must reach max(a,b)-1; never narrower than 1 bit.
    function automatic int tick_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/colour_decoder.sv
// Colour code to one-hot LED drive; codes outside the colour range give all-dark.
module colour_decoder #(
    parameter  int NUM_COLOURS = 4,
    localparam int CW          = $clog2(NUM_COLOURS)
) (
    input  logic [CW-1:0]          code,
    output logic [NUM_COLOURS-1:0] onehot
);

    for (genvar i = 0; i < NUM_COLOURS; i++) begin : g_bit
        assign onehot[i] = (code == CW'(i));
    end

endmodule

// File: rtl/colour_sequencer.sv
// Simon Says playback engine: replays the stored colour sequence on start,
// otherwise mirrors the player's buttons onto the LEDs.
module colour_sequencer
    import simon_pkg::*;
#(
    parameter  int NUM_COLOURS = DEF_NUM_COLOURS,
    parameter  int MAX_STEPS   = DEF_MAX_STEPS,
    parameter  int ON_TICKS    = 25,
    parameter  int GAP_TICKS   = 10,
    localparam int CW          = $clog2(NUM_COLOURS),
    localparam int LW          = $clog2(MAX_STEPS + 1),
    localparam int IW          = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic                           flash_clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [LW-1:0]                  step_count,
    input  logic [MAX_STEPS-1:0][CW-1:0]   segment,
    input  logic [NUM_COLOURS-1:0]         player_input,
    input  logic                           player_enable,
    output logic                           busy,
    output logic                           done,
    output logic [IW-1:0]                  step_idx,
    output logic [NUM_COLOURS-1:0]         disp
);

    localparam int TW = tick_width(ON_TICKS, GAP_TICKS);

    seq_state_t             state, state_d;
    logic [TW-1:0]          tick, tick_d;
    logic [LW-1:0]          len_q, len_d;
    logic [IW-1:0]          idx_d;
    logic [NUM_COLOURS-1:0] lit;
    logic [NUM_COLOURS-1:0] disp_d;
    logic                   busy_d, done_d;

    // Decode from the next step index so the LED register is lit in the same
    // edge that enters ON.
    colour_decoder #(.NUM_COLOURS(NUM_COLOURS)) u_decoder (
        .code   (segment[idx_d]),
        .onehot (lit)
    );

    always_ff @(posedge flash_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick     <= '0;
            len_q    <= '0;
            step_idx <= '0;
            disp     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            tick     <= tick_d;
            len_q    <= len_d;
            step_idx <= idx_d;
            disp     <= disp_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        tick_d  = tick;
        len_d   = len_q;
        idx_d   = step_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    len_d   = (step_count > LW'(MAX_STEPS)) ? LW'(MAX_STEPS) : step_count;
                    idx_d   = '0;
                    tick_d  = '0;
                    state_d = (len_d == '0) ? FINISH : ON;
                end
            end
            ON: begin
                if (tick == TW'(ON_TICKS - 1)) begin
                    tick_d  = '0;
                    state_d = GAP;
                end else begin
                    tick_d = tick + TW'(1);
                end
            end
            GAP: begin
                if (tick == TW'(GAP_TICKS - 1)) begin
                    tick_d = '0;
                    if (LW'(step_idx) == len_q - LW'(1)) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = step_idx + IW'(1);
                        state_d = ON;
                    end
                end else begin
                    tick_d = tick + TW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state; buttons only reach the LEDs in IDLE.
    always_comb begin
        disp_d = '0;
        case (state_d)
            IDLE:    if (player_enable) disp_d = player_input;
            ON:      disp_d = lit;
            default: disp_d = '0;
        endcase
        busy_d = (state_d == ON) || (state_d == GAP);
        done_d = (state_d == FINISH);
    end

endmodule
